// File: rtl/aura_pkg.sv
// Shared types for the attention-tile arithmetic blocks.
// Operand and product widths are set by the INTEGER_WIDTH macro (default 16).
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 16
`endif

package aura_pkg;

    localparam int INTEGER_WIDTH = `INTEGER_WIDTH;
    localparam int NUM_REQ_DEF   = 4;

    typedef logic signed [INTEGER_WIDTH-1:0]   operand_t;
    typedef logic signed [2*INTEGER_WIDTH-1:0] product_t;
    typedef logic [$clog2(NUM_REQ_DEF)-1:0]    tag_t;

endpackage

// File: rtl/mul_tag_fifo.sv
// Tag FIFO recording the owner of every product in flight through the multiplier.
// Pointers wrap explicitly, so any DEPTH >= 1 works.
module mul_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters.
// Define ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
//
// Handshakes: every channel is valid/ready; a transfer happens on a clock edge
// where both are high. Valid never waits on ready.
module mul_share_arbiter
    import aura_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W_IN    = INTEGER_WIDTH,
    parameter int W_OUT   = 2 * W_IN,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_vld,
    output logic [NUM_REQ-1:0]      req_rdy,
    input  logic signed [W_IN-1:0]  req_a [NUM_REQ],
    input  logic signed [W_IN-1:0]  req_b [NUM_REQ],
    output logic [NUM_REQ-1:0]      resp_vld,
    input  logic [NUM_REQ-1:0]      resp_rdy,
    output logic [W_OUT-1:0]        resp_product,
    output logic                    mul_vld,
    input  logic                    mul_rdy,
    output logic signed [W_IN-1:0]  mul_a,
    output logic signed [W_IN-1:0]  mul_b,
    input  logic                    mul_res_vld,
    output logic                    mul_res_rdy,
    input  logic [W_OUT-1:0]        mul_product,
    output logic                    err_orphan
`ifdef ARB_STATS_EN
   ,output logic [CNT_W-1:0]        grant_cnt [NUM_REQ]
`endif
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;
    logic             pop;

    // First requesting index at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                grant = TAG_W'(idx);
            end
        end
    end

    assign mul_vld = !rst && (|req_vld) && !fifo_full;
    assign issue   = mul_vld && mul_rdy;
    assign mul_a   = req_a[grant];
    assign mul_b   = req_b[grant];

    always_comb begin
        req_rdy = '0;
        if (issue) begin
            req_rdy[grant] = 1'b1;
        end
    end

    // Results return in issue order, so the FIFO head names the owner.
    always_comb begin
        resp_vld    = '0;
        mul_res_rdy = 1'b0;
        if (!rst && !fifo_empty) begin
            resp_vld[head] = mul_res_vld;
            mul_res_rdy    = resp_rdy[head];
        end
    end

    assign pop          = mul_res_vld && mul_res_rdy;
    assign resp_product = mul_product;

    mul_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue),
        .push_tag (grant),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (mul_res_vld && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                grant_cnt[i] <= '0;
            end else if (issue && grant == TAG_W'(i) && grant_cnt[i] != {CNT_W{1'b1}}) begin
                grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end
`else
    // CNT_W only sizes the stats counters.
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a two-entry elastic multiplier model.
// Build with ARB_STATS_EN defined to also exercise grant_cnt saturation.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W_IN    = 16;
    localparam int W_OUT   = 32;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 3;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_vld;
    logic [NUM_REQ-1:0]     req_rdy;
    logic signed [W_IN-1:0] req_a [NUM_REQ];
    logic signed [W_IN-1:0] req_b [NUM_REQ];
    logic [NUM_REQ-1:0]     resp_vld;
    logic [NUM_REQ-1:0]     resp_rdy;
    logic [W_OUT-1:0]       resp_product;
    logic                   mul_vld;
    logic                   mul_rdy;
    logic signed [W_IN-1:0] mul_a;
    logic signed [W_IN-1:0] mul_b;
    logic                   mul_res_vld;
    logic                   mul_res_rdy;
    logic [W_OUT-1:0]       mul_product;
    logic                   err_orphan;
`ifdef ARB_STATS_EN
    logic [CNT_W-1:0]       grant_cnt [NUM_REQ];
`endif

    int checks = 0;
    int errors = 0;
    logic force_orphan;

    mul_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .W_IN    (W_IN),
        .W_OUT   (W_OUT),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_vld     (resp_vld),
        .resp_rdy     (resp_rdy),
        .resp_product (resp_product),
        .mul_vld      (mul_vld),
        .mul_rdy      (mul_rdy),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_res_vld  (mul_res_vld),
        .mul_res_rdy  (mul_res_rdy),
        .mul_product  (mul_product),
        .err_orphan   (err_orphan)
`ifdef ARB_STATS_EN
       ,.grant_cnt    (grant_cnt)
`endif
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- multiplier model: one register stage, two-entry output buffer ----
    logic [W_OUT-1:0] mq [2];
    logic [1:0]       mcnt;
    logic [W_OUT-1:0] m_new;
    logic             m_push;
    logic             m_pop;

    assign mul_rdy     = (mcnt != 2'd2);
    assign mul_res_vld = (mcnt != 2'd0) || force_orphan;
    assign mul_product = mq[0];
    assign m_new       = W_OUT'(mul_a) * W_OUT'(mul_b);
    assign m_push      = mul_vld && mul_rdy;
    assign m_pop       = mul_res_vld && mul_res_rdy && (mcnt != 2'd0);

    always @(posedge clk) begin
        if (rst) begin
            mcnt  <= 2'd0;
            mq[0] <= '0;
            mq[1] <= '0;
        end else begin
            case ({m_push, m_pop})
                2'b10: begin
                    mq[mcnt[0]] <= m_new;
                    mcnt        <= mcnt + 2'd1;
                end
                2'b01: begin
                    mq[0] <= mq[1];
                    mcnt  <= mcnt - 2'd1;
                end
                2'b11: begin
                    if (mcnt == 2'd1) begin
                        mq[0] <= m_new;
                    end else begin
                        mq[0] <= mq[1];
                        mq[1] <= m_new;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- driver / checker tasks ----
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] rrdy);
        req_vld  = vld;
        resp_rdy = rrdy;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  rrdy;
        logic [3:0]  exp_req_rdy;
        logic        exp_mul_vld;
        logic [3:0]  exp_resp_vld;
        logic        exp_res_rdy;
        logic [31:0] exp_prod;
    } vec_t;

    vec_t tv [13];

    initial begin
        // products: r0 3*-5=-15, r1 7*4=28, r2 -2*6=-12, r3 10*-3=-30
        req_a[0] = 16'sd3;  req_b[0] = -16'sd5;
        req_a[1] = 16'sd7;  req_b[1] = 16'sd4;
        req_a[2] = -16'sd2; req_b[2] = 16'sd6;
        req_a[3] = 16'sd10; req_b[3] = -16'sd3;

        tv[0]  = '{4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 32'd0};
        tv[1]  = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1, -32'sd15};
        tv[2]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 4'b0000, 1'b0, 32'd0};
        tv[3]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 4'b0010, 1'b1, 32'sd28};
        tv[4]  = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 4'b0100, 1'b1, -32'sd12};
        tv[5]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 4'b1000, 1'b1, -32'sd30};
        tv[6]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 4'b0001, 1'b1, -32'sd15};
        tv[7]  = '{4'b1111, 4'b1101, 4'b0100, 1'b1, 4'b0010, 1'b0, 32'sd28};
        tv[8]  = '{4'b1111, 4'b1101, 4'b0000, 1'b0, 4'b0010, 1'b0, 32'sd28};
        tv[9]  = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b1, 32'sd28};
        tv[10] = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 4'b0100, 1'b1, -32'sd12};
        tv[11] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1, -32'sd30};
        tv[12] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'd0};

        // ---- reset (requests held high to show they are ignored) ----
        rst          = 1'b1;
        force_orphan = 1'b0;
        req_vld      = 4'b1111;
        resp_rdy     = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req_rdy",     32'(req_rdy),     32'd0);
        chk("rst.mul_vld",     32'(mul_vld),     32'd0);
        chk("rst.resp_vld",    32'(resp_vld),    32'd0);
        chk("rst.mul_res_rdy", 32'(mul_res_rdy), 32'd0);
        chk("rst.err_orphan",  32'(err_orphan),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- single issue, round robin, head stall ----
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].vld, tv[i].rrdy);
            chk($sformatf("v%0d.req_rdy", i),     32'(req_rdy),     32'(tv[i].exp_req_rdy));
            chk($sformatf("v%0d.mul_vld", i),     32'(mul_vld),     32'(tv[i].exp_mul_vld));
            chk($sformatf("v%0d.resp_vld", i),    32'(resp_vld),    32'(tv[i].exp_resp_vld));
            chk($sformatf("v%0d.mul_res_rdy", i), 32'(mul_res_rdy), 32'(tv[i].exp_res_rdy));
            if (tv[i].exp_resp_vld != 4'b0000) begin
                chk($sformatf("v%0d.product", i), resp_product, tv[i].exp_prod);
            end
            tick();
        end

        // ---- reset with two products in flight (ptr reaches 3 first) ----
        drive(4'b0110, 4'b0000);
        chk("r4a.req_rdy", 32'(req_rdy), 32'b0010);
        tick();
        drive(4'b0110, 4'b0000);
        chk("r4b.req_rdy",  32'(req_rdy),  32'b0100);
        chk("r4b.resp_vld", 32'(resp_vld), 32'b0010);
        tick();
        rst = 1'b1;
        drive(4'b0000, 4'b0000);
        tick();
        rst = 1'b0;
        drive(4'b0000, 4'b1111);
        chk("r4c.req_rdy",     32'(req_rdy),     32'd0);
        chk("r4c.mul_vld",     32'(mul_vld),     32'd0);
        chk("r4c.resp_vld",    32'(resp_vld),    32'd0);
        chk("r4c.mul_res_rdy", 32'(mul_res_rdy), 32'd0);
        chk("r4c.err_orphan",  32'(err_orphan),  32'd0);
        tick();
        drive(4'b1010, 4'b1111);
        chk("r4d.req_rdy", 32'(req_rdy), 32'b0010);
        tick();
        drive(4'b0000, 4'b1111);
        chk("r4e.resp_vld", 32'(resp_vld),  32'b0010);
        chk("r4e.product",  resp_product,   32'sd28);
        tick();
        drive(4'b0000, 4'b1111);
        chk("r4f.resp_vld", 32'(resp_vld), 32'd0);

        // ---- orphan result ----
        force_orphan = 1'b1;
        #1;
        chk("o5a.resp_vld",    32'(resp_vld),    32'd0);
        chk("o5a.mul_res_rdy", 32'(mul_res_rdy), 32'd0);
        chk("o5a.err_orphan",  32'(err_orphan),  32'd0);
        tick();
        force_orphan = 1'b0;
        #1;
        chk("o5b.err_orphan", 32'(err_orphan), 32'd1);
        tick();
        drive(4'b0001, 4'b1111);
        chk("o5c.req_rdy", 32'(req_rdy), 32'b0001);
        tick();
        drive(4'b0000, 4'b1111);
        chk("o5d.resp_vld",   32'(resp_vld),   32'b0001);
        chk("o5d.product",    resp_product,    -32'sd15);
        chk("o5d.err_orphan", 32'(err_orphan), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("o5e.err_orphan", 32'(err_orphan), 32'd0);

`ifdef ARB_STATS_EN
        // ---- grant counter saturation ----
        for (int i = 0; i < NUM_REQ; i++) begin
            chk($sformatf("s6.cnt%0d_rst", i), 32'(grant_cnt[i]), 32'd0);
        end
        tick();
        for (int n = 0; n < 10; n++) begin
            drive(4'b0100, 4'b1111);
            chk($sformatf("s6.grant%0d", n), 32'(req_rdy), 32'b0100);
            tick();
        end
        drive(4'b0000, 4'b1111);
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            chk($sformatf("s6.cnt%0d", i), 32'(grant_cnt[i]), (i == 2) ? 32'd7 : 32'd0);
        end
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
